// File: rtl/ucaspian_cmd_decoder.sv
// Host byte-stream command decoder for ucaspian_core: parses opcode/operand
// packets, raises one request toward the core and stalls the stream until acked.
module ucaspian_cmd_decoder #(
    parameter int NEURON_CFG_BYTES  = 6,
    parameter int SYNAPSE_CFG_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [11:0] config_addr,
    output logic [11:0] config_value,
    output logic [2:0]  config_byte,
    output logic        config_type,
    input  logic        config_done,
    output logic [7:0]  input_fire_addr,
    output logic [7:0]  input_fire_value,
    output logic        input_fire_waiting,
    input  logic        input_fire_ack,
    output logic [7:0]  time_target_value,
    output logic        time_target_waiting,
    input  logic        time_target_ack,
    output logic        clear_act,
    output logic        clear_config,
    input  logic        clear_done,
    output logic        ack_sent,
    output logic [7:0]  metric_addr,
    output logic        metric_read,
    input  logic        metric_send,
    output logic        busy,
    output logic        cmd_err
);
    typedef enum logic [3:0] {
        IDLE, OPERANDS, CFG_STREAM, CFG_WAIT, FIRE_WAIT,
        TIME_WAIT, CLEAR_WAIT, CLEAR_ACK, METRIC_WAIT
    } state_t;

    typedef enum logic [7:0] {
        OP_FIRE        = 8'h01,
        OP_RUN         = 8'h02,
        OP_CLEAR_ACT   = 8'h03,
        OP_CLEAR_CFG   = 8'h04,
        OP_CFG_NEURON  = 8'h05,
        OP_CFG_SYNAPSE = 8'h06,
        OP_METRIC      = 8'h07
    } opcode_t;

    localparam logic [2:0] NEURON_LAST  = 3'(NEURON_CFG_BYTES - 1);
    localparam logic [2:0] SYNAPSE_LAST = 3'(SYNAPSE_CFG_BYTES - 1);

    state_t     state;
    opcode_t    op;
    logic [2:0] opnd_cnt;
    logic [2:0] data_idx;
    logic       last_opnd;
    logic [2:0] last_idx;

    assign in_rdy    = (state == IDLE) || (state == OPERANDS) || (state == CFG_STREAM);
    assign busy      = (state != IDLE);
    assign last_opnd = (opnd_cnt == 3'd1);
    assign last_idx  = config_type ? SYNAPSE_LAST : NEURON_LAST;

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            op                  <= OP_FIRE;
            opnd_cnt            <= '0;
            data_idx            <= '0;
            config_addr         <= '0;
            config_value        <= '0;
            config_byte         <= 3'd7;
            config_type         <= 1'b0;
            input_fire_addr     <= '0;
            input_fire_value    <= '0;
            input_fire_waiting  <= 1'b0;
            time_target_value   <= '0;
            time_target_waiting <= 1'b0;
            clear_act           <= 1'b0;
            clear_config        <= 1'b0;
            ack_sent            <= 1'b0;
            metric_addr         <= '0;
            metric_read         <= 1'b0;
            cmd_err             <= 1'b0;
        end else begin
            cmd_err  <= 1'b0;
            ack_sent <= 1'b0;
            case (state)
                IDLE: if (in_vld) begin
                    case (in_data)
                        OP_FIRE: begin
                            op <= OP_FIRE; opnd_cnt <= 3'd2; state <= OPERANDS;
                        end
                        OP_RUN: begin
                            op <= OP_RUN; opnd_cnt <= 3'd1; state <= OPERANDS;
                        end
                        OP_CLEAR_ACT: begin
                            clear_act <= 1'b1; state <= CLEAR_WAIT;
                        end
                        OP_CLEAR_CFG: begin
                            clear_config <= 1'b1; state <= CLEAR_WAIT;
                        end
                        OP_CFG_NEURON: begin
                            op <= OP_CFG_NEURON; opnd_cnt <= 3'd1; config_type <= 1'b0;
                            state <= OPERANDS;
                        end
                        OP_CFG_SYNAPSE: begin
                            op <= OP_CFG_SYNAPSE; opnd_cnt <= 3'd2; config_type <= 1'b1;
                            state <= OPERANDS;
                        end
                        OP_METRIC: begin
                            op <= OP_METRIC; opnd_cnt <= 3'd1; state <= OPERANDS;
                        end
                        default: cmd_err <= 1'b1;
                    endcase
                end
                OPERANDS: if (in_vld) begin
                    opnd_cnt <= opnd_cnt - 3'd1;
                    case (op)
                        OP_FIRE: if (!last_opnd) begin
                            input_fire_addr <= in_data;
                        end else begin
                            input_fire_value   <= in_data;
                            input_fire_waiting <= 1'b1;
                            state              <= FIRE_WAIT;
                        end
                        OP_RUN: begin
                            time_target_value   <= in_data;
                            time_target_waiting <= 1'b1;
                            state               <= TIME_WAIT;
                        end
                        OP_METRIC: begin
                            metric_addr <= in_data;
                            metric_read <= 1'b1;
                            state       <= METRIC_WAIT;
                        end
                        OP_CFG_NEURON: begin
                            config_addr <= {4'h0, in_data};
                            data_idx    <= '0;
                            state       <= CFG_STREAM;
                        end
                        OP_CFG_SYNAPSE: if (!last_opnd) begin
                            config_addr[11:8] <= in_data[3:0];
                        end else begin
                            config_addr[7:0] <= in_data;
                            data_idx         <= '0;
                            state            <= CFG_STREAM;
                        end
                        default: state <= IDLE;
                    endcase
                end
                // config_byte only moves on an accepted data byte, so gaps hold it
                CFG_STREAM: if (in_vld) begin
                    config_byte  <= data_idx;
                    config_value <= {4'h0, in_data};
                    if (data_idx == last_idx) state <= CFG_WAIT;
                    else data_idx <= data_idx + 3'd1;
                end
                CFG_WAIT: if (config_done) begin
                    config_byte <= 3'd7;
                    state       <= IDLE;
                end
                FIRE_WAIT: if (input_fire_ack) begin
                    input_fire_waiting <= 1'b0;
                    state              <= IDLE;
                end
                TIME_WAIT: if (time_target_ack) begin
                    time_target_waiting <= 1'b0;
                    state               <= IDLE;
                end
                CLEAR_WAIT: if (clear_done) begin
                    clear_act    <= 1'b0;
                    clear_config <= 1'b0;
                    ack_sent     <= 1'b1;
                    state        <= CLEAR_ACK;
                end
                CLEAR_ACK: state <= IDLE;
                METRIC_WAIT: if (metric_send) begin
                    metric_read <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ucaspian_cmd_decoder.sv
// Bench for ucaspian_cmd_decoder: directed packets from the test plan, then
// random packets checked against a packet-level model of the command set.
module tb_ucaspian_cmd_decoder;
    localparam int NB = 6;
    localparam int SB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_rdy;
    logic [11:0] config_addr;
    logic [11:0] config_value;
    logic [2:0]  config_byte;
    logic        config_type;
    logic        config_done;
    logic [7:0]  input_fire_addr;
    logic [7:0]  input_fire_value;
    logic        input_fire_waiting;
    logic        input_fire_ack;
    logic [7:0]  time_target_value;
    logic        time_target_waiting;
    logic        time_target_ack;
    logic        clear_act;
    logic        clear_config;
    logic        clear_done;
    logic        ack_sent;
    logic [7:0]  metric_addr;
    logic        metric_read;
    logic        metric_send;
    logic        busy;
    logic        cmd_err;

    always #5 clk = ~clk;

    ucaspian_cmd_decoder #(
        .NEURON_CFG_BYTES (NB),
        .SYNAPSE_CFG_BYTES(SB)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_data            (in_data),
        .in_vld             (in_vld),
        .in_rdy             (in_rdy),
        .config_addr        (config_addr),
        .config_value       (config_value),
        .config_byte        (config_byte),
        .config_type        (config_type),
        .config_done        (config_done),
        .input_fire_addr    (input_fire_addr),
        .input_fire_value   (input_fire_value),
        .input_fire_waiting (input_fire_waiting),
        .input_fire_ack     (input_fire_ack),
        .time_target_value  (time_target_value),
        .time_target_waiting(time_target_waiting),
        .time_target_ack    (time_target_ack),
        .clear_act          (clear_act),
        .clear_config       (clear_config),
        .clear_done         (clear_done),
        .ack_sent           (ack_sent),
        .metric_addr        (metric_addr),
        .metric_read        (metric_read),
        .metric_send        (metric_send),
        .busy               (busy),
        .cmd_err            (cmd_err)
    );

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;
    int unsigned cyc    = 0;
    int unsigned tw_cnt = 0;
    int unsigned mr_cnt = 0;
    int unsigned as_cnt = 0;
    int unsigned ce_cnt = 0;
    logic [7:0]  d [10];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse/cycle counters sampled mid-cycle
    always @(negedge clk) begin
        if (time_target_waiting) tw_cnt++;
        if (metric_read) mr_cnt++;
        if (ack_sent) as_cnt++;
        if (cmd_err) ce_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_vld high so consecutive calls stream bytes without gaps
    task automatic send(input logic [7:0] b);
        int unsigned n;
        n = 0;
        in_data = b;
        in_vld  = 1'b1;
        while (!in_rdy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("rdy_timeout", 32'(in_rdy), 32'd1);
        tick();
    endtask

    function automatic logic [5:0] req_vec();
        return {metric_read, config_byte != 3'd7, clear_config, clear_act,
                time_target_waiting, input_fire_waiting};
    endfunction

    // Model: which single request an opcode raises
    function automatic logic [5:0] exp_vec(input logic [7:0] op);
        case (op)
            8'h01: return 6'b000001;
            8'h02: return 6'b000010;
            8'h03: return 6'b000100;
            8'h04: return 6'b001000;
            8'h05, 8'h06: return 6'b010000;
            8'h07: return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic drive_acks(input logic [7:0] op, input logic own, input logic noise);
        input_fire_ack  = (op == 8'h01) ? own : (noise & 1'($urandom_range(0, 1)));
        time_target_ack = (op == 8'h02) ? own : (noise & 1'($urandom_range(0, 1)));
        clear_done      = (op == 8'h03 || op == 8'h04) ? own : (noise & 1'($urandom_range(0, 1)));
        config_done     = (op == 8'h05 || op == 8'h06) ? own : (noise & 1'($urandom_range(0, 1)));
        metric_send     = (op == 8'h07) ? own : (noise & 1'($urandom_range(0, 1)));
    endtask

    task automatic check_fields(input logic [7:0] op, input logic [11:0] caddr, input int unsigned ndata);
        case (op)
            8'h01: begin
                chk("fire_addr", 32'(input_fire_addr), 32'(d[0]));
                chk("fire_value", 32'(input_fire_value), 32'(d[1]));
            end
            8'h02: chk("run_steps", 32'(time_target_value), 32'(d[0]));
            8'h05, 8'h06: begin
                chk("cfg_addr_wait", 32'(config_addr), 32'(caddr));
                chk("cfg_type_wait", 32'(config_type), 32'(op == 8'h06));
                chk("cfg_byte_wait", 32'(config_byte), ndata - 1);
            end
            8'h07: chk("metric_addr", 32'(metric_addr), 32'(d[0]));
            default: ;
        endcase
    endtask

    task automatic check_reset();
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_cfg_byte", 32'(config_byte), 32'd7);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reqs", 32'(req_vec()), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("rst_ack_sent", 32'(ack_sent), 32'd0);
        chk("rst_cfg_addr", 32'(config_addr), 32'd0);
        chk("rst_cfg_value", 32'(config_value), 32'd0);
        chk("rst_cfg_type", 32'(config_type), 32'd0);
        chk("rst_fire", 32'({input_fire_addr, input_fire_value}), 32'd0);
        chk("rst_time_val", 32'(time_target_value), 32'd0);
        chk("rst_metric_addr", 32'(metric_addr), 32'd0);
    endtask

    // Sends one packet (operands/data taken from d), then runs its wait phase
    task automatic do_packet(input logic [7:0] op, input int unsigned delay, input int unsigned gap);
        int unsigned nops;
        int unsigned ndata;
        logic [11:0] caddr;
        logic [7:0]  b;
        nops  = 0;
        ndata = 0;
        caddr = '0;
        case (op)
            8'h01: nops = 2;
            8'h02, 8'h07: nops = 1;
            8'h05: begin nops = 1; ndata = NB; caddr = {4'h0, d[0]}; end
            8'h06: begin nops = 2; ndata = SB; b = d[0]; caddr = {b[3:0], d[1]}; end
            default: nops = 0;
        endcase
        send(op);
        if (op == 8'h00 || op > 8'h07) begin
            in_vld = 1'b0;
            chk("bad_cmd_err", 32'(cmd_err), 32'd1);
            chk("bad_busy", 32'(busy), 32'd0);
            chk("bad_in_rdy", 32'(in_rdy), 32'd1);
            chk("bad_reqs", 32'(req_vec()), 32'd0);
            tick();
            chk("bad_cmd_err_end", 32'(cmd_err), 32'd0);
            return;
        end
        for (int unsigned i = 0; i < nops; i++) send(d[i]);
        for (int unsigned k = 0; k < ndata; k++) begin
            if (gap != 0) begin
                in_vld = 1'b0;
                repeat ($urandom_range(0, gap)) begin
                    tick();
                    chk("cfg_hold", 32'(config_byte), (k == 0) ? 32'd7 : k - 1);
                    chk("cfg_gap_rdy", 32'(in_rdy), 32'd1);
                end
            end
            b = d[nops + k];
            send(b);
            chk("cfg_byte", 32'(config_byte), k);
            chk("cfg_value", 32'(config_value), 32'(b));
            chk("cfg_addr", 32'(config_addr), 32'(caddr));
            chk("cfg_type", 32'(config_type), 32'(op == 8'h06));
        end
        in_vld = 1'b0;
        chk("req_on", 32'(req_vec()), 32'(exp_vec(op)));
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_in_rdy", 32'(in_rdy), 32'd0);
        chk("req_cmd_err", 32'(cmd_err), 32'd0);
        check_fields(op, caddr, ndata);
        repeat (delay) begin
            drive_acks(op, 1'b0, 1'b1);
            tick();
            chk("req_hold", 32'(req_vec()), 32'(exp_vec(op)));
            chk("req_hold_rdy", 32'(in_rdy), 32'd0);
        end
        drive_acks(op, 1'b1, 1'b0);
        tick();
        drive_acks(op, 1'b0, 1'b0);
        if (op == 8'h03 || op == 8'h04) begin
            chk("clr_off", 32'(req_vec()), 32'd0);
            chk("clr_ack_sent", 32'(ack_sent), 32'd1);
            chk("clr_ack_rdy", 32'(in_rdy), 32'd0);
            chk("clr_ack_busy", 32'(busy), 32'd1);
            tick();
            chk("clr_ack_end", 32'(ack_sent), 32'd0);
            chk("clr_idle_rdy", 32'(in_rdy), 32'd1);
            chk("clr_idle_busy", 32'(busy), 32'd0);
        end else begin
            chk("req_off", 32'(req_vec()), 32'd0);
            chk("req_off_rdy", 32'(in_rdy), 32'd1);
            chk("req_off_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int unsigned r;
        int unsigned t0;
        int unsigned c0;
        int unsigned c1;
        logic [7:0]  op;

        reset   = 1'b1;
        in_data = '0;
        in_vld  = 1'b0;
        drive_acks(8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        check_reset();

        // FIRE with ack three cycles into the wait
        d[0] = 8'h2A; d[1] = 8'h7F;
        do_packet(8'h01, 3, 0);

        // CFG_SYNAPSE, addr 0x310
        d[0] = 8'h03; d[1] = 8'h10; d[2] = 8'hA1; d[3] = 8'hB2; d[4] = 8'hC3; d[5] = 8'hD4;
        do_packet(8'h06, 2, 0);
        chk("syn_addr_const", 32'(config_addr), 32'h310);

        // CLEAR_ACT with clear_done 20 cycles late
        c0 = as_cnt;
        do_packet(8'h03, 20, 0);
        chk("clr_single_ack", as_cnt - c0, 32'd1);

        // RUN then METRIC streamed back-to-back, acks held high
        t0 = cyc; c0 = tw_cnt; c1 = mr_cnt;
        time_target_ack = 1'b1;
        metric_send     = 1'b1;
        send(8'h02);
        send(8'h05);
        chk("b2b_run_on", 32'(time_target_waiting), 32'd1);
        chk("b2b_run_val", 32'(time_target_value), 32'd5);
        send(8'h07);
        send(8'h09);
        in_vld = 1'b0;
        chk("b2b_metric_on", 32'(metric_read), 32'd1);
        chk("b2b_metric_addr", 32'(metric_addr), 32'd9);
        tick();
        time_target_ack = 1'b0;
        metric_send     = 1'b0;
        chk("b2b_metric_off", 32'(metric_read), 32'd0);
        chk("b2b_idle_rdy", 32'(in_rdy), 32'd1);
        chk("b2b_cycles", cyc - t0, 32'd6);
        chk("b2b_run_once", tw_cnt - c0, 32'd1);
        chk("b2b_metric_once", mr_cnt - c1, 32'd1);

        // Bad opcode then a normal FIRE
        c0 = ce_cnt;
        do_packet(8'hFF, 0, 0);
        d[0] = 8'h11; d[1] = 8'h22;
        do_packet(8'h01, 1, 0);
        chk("bad_single_err", ce_cnt - c0, 32'd1);

        // Reset in the middle of a CFG_NEURON stream
        c0 = as_cnt;
        send(8'h05);
        send(8'h44);
        send(8'h10);
        send(8'h20);
        send(8'h30);
        in_vld = 1'b0;
        chk("mid_cfg_byte", 32'(config_byte), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset();
        chk("mid_no_ack_sent", as_cnt - c0, 32'd0);
        d[0] = 8'h5C;
        do_packet(8'h07, 0, 0);
        d[0] = 8'h81; d[1] = 8'h01; d[2] = 8'h02; d[3] = 8'h03; d[4] = 8'h04; d[5] = 8'h05; d[6] = 8'h06;
        do_packet(8'h05, 1, 1);

        // Random packets, including bad opcodes, data gaps and spurious acks
        for (int unsigned p = 0; p < 80; p++) begin
            r = $urandom_range(0, 7);
            if (r < 7) op = 8'(r + 1);
            else if ($urandom_range(0, 3) == 0) op = 8'h00;
            else op = 8'($urandom_range(8, 255));
            for (int unsigned i = 0; i < 10; i++) d[i] = 8'($urandom);
            do_packet(op, $urandom_range(0, 4), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
